// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC and fetches one word per request over a
// req/ack memory handshake, then strobes it into the instruction register.
module instr_fetch #(
  parameter int unsigned DW       = 18,
  parameter int unsigned AW       = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_en,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_load_val,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] ir_data,
  output logic          wr_IR,
  output logic          busy,
  output logic [AW-1:0] pc
);

  localparam logic [AW-1:0] ResetPc = AW'(RESET_PC);
  localparam logic [AW-1:0] PcOne   = AW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWrite
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          squash_q, squash_d;
  logic [DW-1:0] ir_q, ir_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      pc_q     <= ResetPc;
      addr_q   <= ResetPc;
      rd_q     <= 1'b0;
      squash_q <= 1'b0;
      ir_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      squash_q <= squash_d;
      ir_q     <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    squash_d = squash_q;
    ir_d     = ir_q;
    unique case (state_q)
      StIdle: begin
        if (pc_load) begin
          pc_d = pc_load_val;
        end
        if (fetch_en) begin
          state_d = StReq;
          rd_d    = 1'b1;
          addr_d  = pc_load ? pc_load_val : pc_q;
        end
      end
      StReq: begin
        if (!rd_q) begin
          // One-cycle gap after a squashed ack: reissue at the redirected PC.
          rd_d   = 1'b1;
          addr_d = pc_load ? pc_load_val : pc_q;
          if (pc_load) begin
            pc_d = pc_load_val;
          end
        end else begin
          if (pc_load) begin
            pc_d = pc_load_val;
          end
          if (mem_ack) begin
            rd_d = 1'b0;
            // A redirect in the ack cycle also makes the returning word stale.
            if (squash_q || pc_load) begin
              squash_d = 1'b0;
            end else begin
              ir_d    = mem_data;
              state_d = StWrite;
            end
          end else if (pc_load) begin
            squash_d = 1'b1;
          end
        end
      end
      StWrite: begin
        pc_d    = pc_load ? pc_load_val : pc_q + PcOne;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign mem_addr = addr_q;
  assign mem_rd   = rd_q;
  assign ir_data  = ir_q;
  assign pc       = pc_q;
  assign wr_IR    = (state_q == StWrite);
  assign busy     = (state_q != StIdle);

endmodule
